// File: rtl/led_arbiter.sv
// led_arbiter: two-requester LED owner arbiter with a free-running heartbeat.
// The CPU and a hardware status source compete for the eight green LEDs.
// Grants are fair on ties through a last-grant pointer. An owner is preempted
// after MAX_HOLD cycles only when the other side is waiting. Every handover
// passes through a one-cycle GAP. When nobody owns the LEDs, LEDG[0] shows
// the heartbeat.
module led_arbiter #(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       cpu_req,
  input  logic [7:0] cpu_data,
  input  logic       hw_req,
  input  logic [7:0] hw_data,
  output logic       cpu_gnt,
  output logic       hw_gnt,
  output logic [7:0] LEDG
);

  localparam int DATA_W = 8;
  localparam int HB_W   = 32;
  localparam int HOLD_W = 16;

  localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_HW  = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [HB_W-1:0]     hb_cnt;
  logic                hb;
  logic                hb_wrap;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_full;
  logic                last_hw;
  logic                gnt_entry;
  logic                in_gnt;
  logic [DATA_W-1:0]   led_nxt;

  // Shared decision used in both IDLE and GAP. On a tie, the requester that
  // did not own the LEDs last time wins.
  function automatic state_t arbitrate(input logic c_req, input logic h_req,
                                       input logic last_was_hw);
    state_t res;
    if (c_req && h_req) begin
      res = last_was_hw ? GNT_CPU : GNT_HW;
    end else if (c_req) begin
      res = GNT_CPU;
    end else if (h_req) begin
      res = GNT_HW;
    end else begin
      res = IDLE;
    end
    return res;
  endfunction

  assign hb_wrap   = (hb_cnt == HB_LAST);
  assign hold_full = (hold_cnt == HOLD_LAST);
  assign in_gnt    = (state == GNT_CPU) || (state == GNT_HW);
  // A grant state is only ever entered from IDLE or GAP, so a change of state
  // into GNT_x is always a fresh entry.
  assign gnt_entry = ((state_nxt == GNT_CPU) || (state_nxt == GNT_HW)) &&
                     (state_nxt != state);

  // Heartbeat divider: runs in every state; hb flips on each wrap.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (hb_wrap) begin
      hb_cnt <= '0;
      hb     <= ~hb;
    end else begin
      hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

  // Next-state logic. When the owner drops its request and preemption fall
  // due on the same cycle, both lead to GAP, so the order of tests does not
  // change the result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, GAP: begin
        state_nxt = arbitrate(cpu_req, hw_req, last_hw);
      end
      GNT_CPU: begin
        if (!cpu_req) begin
          state_nxt = GAP;
        end else if (hw_req && hold_full) begin
          state_nxt = GAP;
        end
      end
      GNT_HW: begin
        if (!hw_req) begin
          state_nxt = GAP;
        end else if (cpu_req && hold_full) begin
          state_nxt = GAP;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // LED source for the coming cycle. The owner's data is sampled on the
  // grant edge itself. GAP freezes the last pattern. IDLE shows hb as it
  // stood before the edge, so LEDG lags hb by one clock.
  always_comb begin
    led_nxt = LEDG;
    case (state_nxt)
      GNT_CPU: led_nxt = cpu_data;
      GNT_HW:  led_nxt = hw_data;
      GAP:     led_nxt = LEDG;
      default: led_nxt = {{(DATA_W-1){1'b0}}, hb};
    endcase
  end

  // State register, registered grants and last-grant pointer.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      state   <= IDLE;
      cpu_gnt <= 1'b0;
      hw_gnt  <= 1'b0;
      last_hw <= 1'b1;
    end else begin
      state   <= state_nxt;
      cpu_gnt <= (state_nxt == GNT_CPU);
      hw_gnt  <= (state_nxt == GNT_HW);
      if (gnt_entry) begin
        last_hw <= (state_nxt == GNT_HW);
      end
    end
  end

  // Hold counter: cleared on grant entry, counts grant cycles, and sticks at
  // MAX_HOLD-1 so an uncontested owner can keep the LEDs indefinitely.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      hold_cnt <= '0;
    end else if (gnt_entry) begin
      hold_cnt <= '0;
    end else if (in_gnt && !hold_full) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // LED output register.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      LEDG <= '0;
    end else begin
      LEDG <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: directed checks of led_arbiter with TICK_DIV=4, MAX_HOLD=8.
module tb_led_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req;
  logic [7:0] cpu_data;
  logic       hw_req;
  logic [7:0] hw_data;
  logic       cpu_gnt;
  logic       hw_gnt;
  logic [7:0] ledg;

  int vectors;
  int miscompares;

  led_arbiter #(
    .TICK_DIV(4),
    .MAX_HOLD(8)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst_n),
    .cpu_req (cpu_req),
    .cpu_data(cpu_data),
    .hw_req  (hw_req),
    .hw_data (hw_data),
    .cpu_gnt (cpu_gnt),
    .hw_gnt  (hw_gnt),
    .LEDG    (ledg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare {cpu_gnt, hw_gnt, LEDG} against the expected value.
  task automatic chk(input string tag, input logic [9:0] expv);
    logic [9:0] obs;
    obs = {cpu_gnt, hw_gnt, ledg};
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed gnt=%b%b led=%h expected gnt=%b%b led=%h",
             tag, obs[9], obs[8], obs[7:0], expv[9], expv[8], expv[7:0]);
    end
  endtask

  // In IDLE, LEDG after edge n (counted from reset release) shows hb as it
  // stood after edge n-1; hb flips every 4th edge with TICK_DIV=4.
  function automatic logic [7:0] hb_led(input int n);
    return {7'b0, 1'(((n - 1) / 4) % 2)};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    cpu_req  = 1'b0;
    hw_req   = 1'b0;
    cpu_data = 8'h00;
    hw_data  = 8'h00;

    // Reset state.
    step();
    step();
    step();
    chk("reset", 10'b00_0000_0000);

    // Heartbeat: idle for 20 clocks.
    rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("heartbeat_%0d", n), {2'b00, hb_led(n)});
    end

    // Single CPU grant, data tracking, foreign data ignored, release.
    cpu_req  = 1'b1;
    cpu_data = 8'hA5;
    hw_data  = 8'hFF;
    step();                                    // edge 21
    chk("cpu_grant", {2'b10, 8'hA5});
    cpu_data = 8'h5A;
    hw_data  = 8'h0F;
    step();                                    // edge 22
    chk("cpu_data_track", {2'b10, 8'h5A});
    cpu_req = 1'b0;
    step();                                    // edge 23
    chk("cpu_release_gap", {2'b00, 8'h5A});
    step();                                    // edge 24
    chk("idle_hb_24", {2'b00, hb_led(24)});
    step();                                    // edge 25
    chk("idle_hb_25", {2'b00, hb_led(25)});

    // Tie after reset goes to the CPU; HW follows after GAP.
    rst_n = 1'b0;
    step();
    chk("reset2", 10'b00_0000_0000);
    rst_n    = 1'b1;
    cpu_req  = 1'b1;
    hw_req   = 1'b1;
    cpu_data = 8'h11;
    hw_data  = 8'h22;
    step();
    chk("tie_cpu", {2'b10, 8'h11});
    cpu_req = 1'b0;
    step();
    chk("tie_gap", {2'b00, 8'h11});
    step();
    chk("tie_hw", {2'b01, 8'h22});
    hw_req = 1'b0;
    step();
    chk("hw_release_gap", {2'b00, 8'h22});
    step();
    chk("back_idle", {2'b00, 8'h00} | {2'b00, 8'h01} & {2'b00, ledg});

    // Preemption: the pointer says HW was last, so the tie goes to the CPU.
    cpu_req  = 1'b1;
    hw_req   = 1'b1;
    cpu_data = 8'hC1;
    hw_data  = 8'hD2;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("preempt_cpu_%0d", k), {2'b10, 8'hC1});
    end
    step();
    chk("preempt_cpu_gap", {2'b00, 8'hC1});
    step();
    chk("preempt_hw_0", {2'b01, 8'hD2});
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("preempt_hw_%0d", k), {2'b01, 8'hD2});
    end
    step();
    chk("preempt_hw_gap", {2'b00, 8'hD2});
    step();
    chk("regrant_cpu", {2'b10, 8'hC1});

    // Saturation: no contender for 100 clocks keeps the CPU in place.
    hw_req = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      chk($sformatf("saturate_%0d", k), {2'b10, 8'hC1});
    end
    hw_req = 1'b1;
    step();
    chk("saturate_preempt_gap", {2'b00, 8'hC1});
    step();
    chk("saturate_hw", {2'b01, 8'hD2});
    hw_data = 8'h3C;
    step();
    chk("hw_3c", {2'b01, 8'h3C});

    // Reset mid-grant: immediate, no GAP; then the tie goes to the CPU.
    rst_n = 1'b0;
    step();
    chk("reset_mid_grant", 10'b00_0000_0000);
    rst_n = 1'b1;
    step();
    chk("post_reset_tie_cpu", {2'b10, 8'hC1});

    // Owner drops its request on the same cycle preemption falls due.
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("coincide_cpu_%0d", k), {2'b10, 8'hC1});
    end
    cpu_req = 1'b0;
    step();
    chk("coincide_gap", {2'b00, 8'hC1});
    step();
    chk("coincide_hw", {2'b01, 8'h3C});

    // Requests withdrawn during GAP: decision uses the values seen in GAP.
    hw_req = 1'b0;
    step();
    chk("withdraw_gap", {2'b00, 8'h3C});
    cpu_req = 1'b0;
    step();
    chk("withdraw_idle_gnt", {2'b00, 8'h00} | {2'b00, 8'h01} & {2'b00, ledg});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 25_000_000, which is the number of clocks per heartbeat toggle (1 Hz blink at 50 MHz); legal range 2..2^32-1.
REQ-002 SHALL provide parameter MAX_HOLD, default 1024, which is the number of clocks a grant may be held while the other requester waits; legal range 2..65535.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cpu_req  input  1  CPU requester (GPIO export side) wants the LEDs.
REQ-006 SHALL have port cpu_data  input  8  CPU LED pattern.
REQ-007 SHALL have port hw_req  input  1  hardware status requester wants the LEDs.
REQ-008 SHALL have port hw_data  input  8  hardware LED pattern.
REQ-009 SHALL have port cpu_gnt  output  1  CPU owns the LEDs (registered).
REQ-010 SHALL have port hw_gnt  output  1  hardware owns the LEDs (registered).
REQ-011 SHALL have port LEDG  output  8  LED drive (registered).

Function
REQ-012 SHALL implement FSM states IDLE, GNT_CPU, GNT_HW and GAP; cpu_gnt=1 only in GNT_CPU, hw_gnt=1 only in GNT_HW, and never both.
REQ-013 SHALL run a heartbeat counter continuously in every state: it counts 0..TICK_DIV-1 and wraps to 0, and hb toggles on the wrap edge.
REQ-014 SHALL drive LEDG={7'b0,hb} in IDLE, registered, so LEDG[0] follows hb one clock after the toggle.
REQ-015 SHALL use the same arbitration in IDLE and GAP: with only one req high, grant it; with both high, grant the requester not named by the last-grant pointer; with none high, go to (or stay in) IDLE.
REQ-016 SHALL update the last-grant pointer on every entry to a GNT state.
REQ-017 SHALL make grant latency one clock: req sampled high at edge N gives gnt=1 after edge N, and on that same edge LEDG samples the owner's data.
REQ-018 SHALL sample the owner's data into LEDG on every clock while in GNT_x.
REQ-019 SHALL keep a hold counter that clears on GNT entry, increments each clock in GNT, and saturates at MAX_HOLD-1.
REQ-020 SHALL leave GNT_x for GAP when x_req is sampled low.
REQ-021 SHALL also leave GNT_x for GAP (preemption) when the other req is high and the hold counter equals MAX_HOLD-1, giving the owner exactly MAX_HOLD grant cycles.
REQ-022 SHALL keep the owner in GNT_x past MAX_HOLD, with the counter saturated, while the other req is low.
REQ-023 SHALL make GAP last exactly one clock, with both gnt=0 and LEDG holding its last value, followed by REQ-015 arbitration.
REQ-024 SHALL give priority to owner req-low over preemption when both occur on the same clock; the result is identical (GAP).
REQ-025 SHALL ignore a requester's data while it is not granted.
REQ-026 SHALL not depend on req staying high during GAP; the decision uses reqs sampled in GAP.

Reset
REQ-027 SHALL, while RESET=0 at a clock edge, set the state to IDLE, cpu_gnt=0, hw_gnt=0, LEDG=8'h00, hb=0, the heartbeat counter to 0, the hold counter to 0, and the last-grant pointer to HW (so the CPU wins the first tie).
REQ-028 SHALL treat reset mid-grant as immediate: outputs reach reset values after that edge with no GAP cycle.
REQ-029 SHALL, on the first edge with RESET=1, evaluate arbitration normally.

Verification (TICK_DIV=4, MAX_HOLD=8)
REQ-030 SHALL cover heartbeat: no reqs for 20 clocks after reset -> LEDG alternates 8'h00/8'h01 every 4 clocks, first 8'h01 at clock 5.
REQ-031 SHALL cover single grant: cpu_req=1, cpu_data=8'hA5 at edge N -> cpu_gnt=1 and LEDG=8'hA5 after N; drop cpu_req -> GAP (gnt=0, LEDG=8'hA5) -> IDLE with heartbeat.
REQ-032 SHALL cover tie after reset: both reqs rise together -> CPU granted; CPU releases -> GAP -> HW granted, LEDG=hw_data.
REQ-033 SHALL cover preemption: CPU owns, hw_req held high -> cpu_gnt high exactly 8 clocks, 1 GAP clock, then hw_gnt=1; CPU re-granted only after HW releases or is itself preempted after 8 clocks.
REQ-034 SHALL cover saturation: CPU owns with hw_req low for 100 clocks -> no GAP; hw_req rises -> cpu_gnt drops after the next edge.
REQ-035 SHALL cover reset mid-grant: RESET=0 for 1 clock during GNT_HW with LEDG=8'h3C -> next output cpu_gnt=0, hw_gnt=0, LEDG=8'h00; tie then grants CPU.
